// File: rtl/rr_arb_mux.sv
// Registered N:1 arbitrated multiplexer with valid/ready flow control on every channel.
// A round-robin or fixed-priority arbiter picks one input per cycle into a single output register.
package common_pkg;
    localparam int DEFAULT_D_W = 32;
endpackage

module rr_arb_mux
    import common_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = DEFAULT_D_W,
    parameter bit RR = 1'b1,
    localparam int L = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        i_valid,
    output logic [N-1:0]        i_ready,
    input  logic [N-1:0][W-1:0] i,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [W-1:0]        o,
    output logic [L-1:0]        o_sel
);

    logic [W-1:0] o_q, o_d;
    logic [L-1:0] o_sel_q, o_sel_d;
    logic         o_valid_q, o_valid_d;
    logic [L-1:0] ptr_q, ptr_d;

    logic         load_en;
    logic         grant_valid;
    logic [L-1:0] grant;
    int           base_idx;
    int           scan_idx;

    assign load_en = !o_valid_q || o_ready;

    // Search starts at ptr and wraps at N (not 2^L), so non-power-of-two N never yields an invalid index.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        base_idx    = RR ? int'(ptr_q) : 0;
        scan_idx    = 0;
        for (int off = 0; off < N; off++) begin
            scan_idx = base_idx + off;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!grant_valid && i_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant       = L'(scan_idx);
            end
        end
    end

    // Ready is gated by rst_n so no handshake can be offered while reset is held.
    always_comb begin
        i_ready = '0;
        for (int k = 0; k < N; k++) begin
            i_ready[k] = rst_n && load_en && grant_valid && (grant == L'(k));
        end
    end

    always_comb begin
        o_d       = o_q;
        o_sel_d   = o_sel_q;
        o_valid_d = o_valid_q;
        ptr_d     = ptr_q;
        if (load_en && grant_valid) begin
            o_d       = i[grant];
            o_sel_d   = grant;
            o_valid_d = 1'b1;
            if (RR) begin
                ptr_d = (grant == L'(N - 1)) ? '0 : grant + L'(1);
            end
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '0;
            o_sel_q   <= '0;
            o_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            o_q       <= o_d;
            o_sel_q   <= o_sel_d;
            o_valid_q <= o_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign o       = o_q;
    assign o_sel   = o_sel_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin N=4, round-robin N=3 and fixed-priority N=4 instances.
module tb_rr_arb_mux;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [3:0]        a_valid, a_ready;
    logic [3:0][W-1:0] a_i;
    logic              a_o_valid, a_o_ready;
    logic [W-1:0]      a_o;
    logic [1:0]        a_o_sel;

    logic [2:0]        b_valid, b_ready;
    logic [2:0][W-1:0] b_i;
    logic              b_o_valid, b_o_ready;
    logic [W-1:0]      b_o;
    logic [1:0]        b_o_sel;

    logic [3:0]        c_valid, c_ready;
    logic [3:0][W-1:0] c_i;
    logic              c_o_valid, c_o_ready;
    logic [W-1:0]      c_o;
    logic [1:0]        c_o_sel;

    rr_arb_mux #(.N(4), .W(W), .RR(1'b1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_ready(a_ready), .i(a_i),
        .o_valid(a_o_valid), .o_ready(a_o_ready), .o(a_o), .o_sel(a_o_sel)
    );

    rr_arb_mux #(.N(3), .W(W), .RR(1'b1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_ready(b_ready), .i(b_i),
        .o_valid(b_o_valid), .o_ready(b_o_ready), .o(b_o), .o_sel(b_o_sel)
    );

    rr_arb_mux #(.N(4), .W(W), .RR(1'b0)) u_fp4 (
        .clk(clk), .rst_n(rst_n), .i_valid(c_valid), .i_ready(c_ready), .i(c_i),
        .o_valid(c_o_valid), .o_ready(c_o_ready), .o(c_o), .o_sel(c_o_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 4'b1111; a_o_ready = 1'b1;
        for (int k = 0; k < 4; k++) a_i[k] = W'(k + 'h40);
        b_valid = '0; b_o_ready = 1'b1; b_i = '0;
        c_valid = '0; c_o_ready = 1'b1; c_i = '0;
        #1;
        tests++; if (a_ready !== 4'b0000) begin fails++; $display("FAIL reset_iready got %b want %b", a_ready, 4'b0000); end
        tests++; if (a_o_valid !== 1'b0) begin fails++; $display("FAIL reset_ovalid got %b want 0", a_o_valid); end
        step();
        #2 rst_n = 1'b1;
        a_valid = 4'b0001;
        step();
        tests++; if (a_o_valid !== 1'b1 || a_o !== W'('h40)) begin fails++; $display("FAIL pre_reset_load got v=%b o=%h want v=1 o=40", a_o_valid, a_o); end
        // Assert reset mid-cycle with a word held and valid still driven.
        a_valid = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (a_o_valid !== 1'b0) begin fails++; $display("FAIL async_ovalid got %b want 0", a_o_valid); end
        tests++; if (a_o !== '0) begin fails++; $display("FAIL async_o got %h want 0", a_o); end
        tests++; if (a_o_sel !== 2'd0) begin fails++; $display("FAIL async_osel got %0d want 0", a_o_sel); end
        tests++; if (a_ready !== 4'b0000) begin fails++; $display("FAIL async_iready got %b want 0000", a_ready); end
        a_valid = 4'b0000;
        #1 rst_n = 1'b1;
        step();
        step();
        tests++; if (a_o_valid !== 1'b0) begin fails++; $display("FAIL idle_ovalid got %b want 0", a_o_valid); end
        // With every channel valid, a cleared pointer grants channel 0 first.
        a_valid = 4'b1111;
        #1;
        tests++; if (a_ready !== 4'b0001) begin fails++; $display("FAIL reset_ptr got %b want 0001", a_ready); end
        a_valid = 4'b0000;
        step();
    endtask

    task automatic test_single();
        a_valid = 4'b0100; a_o_ready = 1'b1;
        a_i[2] = W'('hA5);
        #1;
        tests++; if (a_ready !== 4'b0100) begin fails++; $display("FAIL single_iready got %b want 0100", a_ready); end
        step();
        tests++; if (a_o !== W'('hA5)) begin fails++; $display("FAIL single_o got %h want a5", a_o); end
        tests++; if (a_o_sel !== 2'd2) begin fails++; $display("FAIL single_osel got %0d want 2", a_o_sel); end
        tests++; if (a_o_valid !== 1'b1) begin fails++; $display("FAIL single_ovalid got %b want 1", a_o_valid); end
        a_valid = 4'b1111;
        #1;
        tests++; if (a_ready !== 4'b1000) begin fails++; $display("FAIL single_ptr got %b want 1000", a_ready); end
        a_valid = 4'b0000;
        step();
        tests++; if (a_o_valid !== 1'b0) begin fails++; $display("FAIL drain_ovalid got %b want 0", a_o_valid); end
        tests++; if (a_o !== W'('hA5) || a_o_sel !== 2'd2) begin fails++; $display("FAIL drain_hold got o=%h sel=%0d want o=a5 sel=2", a_o, a_o_sel); end
        tests++; if (a_ready !== 4'b0000) begin fails++; $display("FAIL idle_iready got %b want 0000", a_ready); end
    endtask

    task automatic test_fairness();
        logic [1:0] es;
        for (int k = 0; k < 4; k++) a_i[k] = W'(k + 'h10);
        a_o_ready = 1'b1;
        a_valid = 4'b1000;
        step();
        tests++; if (a_o_sel !== 2'd3) begin fails++; $display("FAIL rr_prime_sel got %0d want 3", a_o_sel); end
        a_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            step();
            es = 2'(n % 4);
            tests++;
            if (a_o_valid !== 1'b1 || a_o_sel !== es || a_o !== W'(32'(n % 4) + 32'h10)) begin
                fails++;
                $display("FAIL rr_seq[%0d] got v=%b sel=%0d o=%h want v=1 sel=%0d o=%h", n, a_o_valid, a_o_sel, a_o, es, 32'(n % 4) + 32'h10);
            end
        end
    endtask

    task automatic test_backpressure();
        a_valid = 4'b1111; a_o_ready = 1'b1;
        step();
        tests++; if (a_o_sel !== 2'd0 || a_o !== W'('h10)) begin fails++; $display("FAIL bp_first got sel=%0d o=%h want sel=0 o=10", a_o_sel, a_o); end
        a_o_ready = 1'b0;
        #1;
        tests++; if (a_ready !== 4'b0000) begin fails++; $display("FAIL bp_iready got %b want 0000", a_ready); end
        for (int n = 0; n < 3; n++) begin
            step();
            tests++;
            if (a_o_valid !== 1'b1 || a_o_sel !== 2'd0 || a_o !== W'('h10) || a_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_stall[%0d] got v=%b sel=%0d o=%h rdy=%b want v=1 sel=0 o=10 rdy=0000", n, a_o_valid, a_o_sel, a_o, a_ready);
            end
        end
        a_o_ready = 1'b1;
        #1;
        tests++; if (a_ready !== 4'b0010) begin fails++; $display("FAIL bp_resume_iready got %b want 0010", a_ready); end
        step();
        tests++; if (a_o_sel !== 2'd1 || a_o !== W'('h11)) begin fails++; $display("FAIL bp_resume1 got sel=%0d o=%h want sel=1 o=11", a_o_sel, a_o); end
        step();
        tests++; if (a_o_sel !== 2'd2 || a_o !== W'('h12)) begin fails++; $display("FAIL bp_resume2 got sel=%0d o=%h want sel=2 o=12", a_o_sel, a_o); end
        a_valid = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 3; k++) b_i[k] = W'(k + 'h20);
        b_o_ready = 1'b1;
        b_valid = 3'b010;
        step();
        tests++; if (b_o_sel !== 2'd1) begin fails++; $display("FAIL wrap_prime got %0d want 1", b_o_sel); end
        b_valid = 3'b011;
        #1;
        tests++; if (b_ready !== 3'b001) begin fails++; $display("FAIL wrap_iready got %b want 001", b_ready); end
        step();
        tests++; if (b_o_sel !== 2'd0 || b_o !== W'('h20)) begin fails++; $display("FAIL wrap_grant got sel=%0d o=%h want sel=0 o=20", b_o_sel, b_o); end
        b_valid = 3'b111;
        #1;
        tests++; if (b_ready !== 3'b010) begin fails++; $display("FAIL wrap_ptr got %b want 010", b_ready); end
        b_valid = 3'b100;
        step();
        tests++; if (b_o_sel !== 2'd2 || b_o !== W'('h22)) begin fails++; $display("FAIL wrap_last got sel=%0d o=%h want sel=2 o=22", b_o_sel, b_o); end
        b_valid = 3'b000;
        step();
    endtask

    task automatic test_fixed();
        c_o_ready = 1'b1;
        c_valid = 4'b1010;
        c_i[3] = W'('hEE);
        for (int n = 0; n < 3; n++) begin
            c_i[1] = W'(n + 'h30);
            #1;
            tests++; if (c_ready !== 4'b0010) begin fails++; $display("FAIL fp_iready[%0d] got %b want 0010", n, c_ready); end
            step();
            tests++;
            if (c_o_sel !== 2'd1 || c_o !== W'(n + 'h30) || c_o_valid !== 1'b1) begin
                fails++;
                $display("FAIL fp_out[%0d] got v=%b sel=%0d o=%h want v=1 sel=1 o=%h", n, c_o_valid, c_o_sel, c_o, n + 'h30);
            end
        end
        c_valid = 4'b1000;
        step();
        tests++; if (c_o_sel !== 2'd3 || c_o !== W'('hEE)) begin fails++; $display("FAIL fp_alone got sel=%0d o=%h want sel=3 o=ee", c_o_sel, c_o); end
        c_valid = 4'b0000;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_fixed();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered, flow-controlled N:1 arbitrated multiplexer; sequential successor to the plain combinational mux.
- N valid/ready input channels compete for one output. A round-robin (or fixed-priority) arbiter picks one winner per cycle, and its word is captured in a single output register.
- Serves as the output-port stage of NoC switch/router datapaths, where the select comes from arbitration rather than an external select line.

Parameters:
- N, 4, number of input channels; legal range 2..64, need not be a power of two.
- W, DEFAULT_D_W (common_pkg), width of each input word and of the output word.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- L, $clog2(N), localparam; width of the grant index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  [N-1:0]  per-channel word-valid.
- i_ready  output  [N-1:0]  per-channel accept; a word on channel k transfers when i_valid[k] & i_ready[k].
- i  input  [N-1:0][W-1:0]  per-channel data.
- o_valid  output  1  output register holds a word.
- o_ready  input  1  downstream accept.
- o  output  [W-1:0]  registered output data.
- o_sel  output  [L-1:0]  channel index of the word currently in the output register.

Behaviour:
- Reset (async assert, synchronous release):
  - o_valid=0, o=0, o_sel=0.
  - Round-robin pointer ptr=0.
  - Any word held in the output register when reset asserts mid-operation is discarded.
  - i_ready=0 while rst_n=0.
- Load enable: load_en = !o_valid | o_ready.
  - The register accepts a new word when empty or when its current word is being consumed in the same cycle.
  - This gives full throughput: one word per cycle.
- Grant, computed combinationally from i_valid, ptr and RR:
  - RR=1: the first asserted i_valid searched from index ptr upward, wrapping from N-1 to 0. Wrap is at N, not 2^L.
  - RR=0: the lowest asserted index; ptr is unused.
  - No i_valid asserted: no grant.
- i_ready[k] = load_en & grant_valid & (grant==k).
  - At most one i_ready is high per cycle, and never toward a channel with i_valid=0.
  - i_ready depends combinationally on i_valid and o_ready; this path is intentional. There is no path from i to any output.
- Transfer (i_valid[g] & i_ready[g]): next edge sets o<=i[g], o_sel<=g, o_valid<=1.
  - RR=1: ptr<=(g==N-1)?0:g+1.
- Output consumed with no new grant (o_valid & o_ready & no grant): o_valid<=0. o and o_sel hold their last values.
- Stall (o_valid & !o_ready): o, o_sel, o_valid and ptr all hold; every i_ready=0.
- ptr changes only on a transfer. Idle cycles and stalls do not advance it.
- Latency: input to o_valid is exactly 1 cycle.
- Starvation bound (RR=1): a continuously valid channel is granted within N transfers.
- Inputs are not required to hold i_valid stable until accepted; the arbiter does not lock.

Test Plan:
- Reset/idle: drive rst_n=0 mid-transfer (o_valid=1) -> o_valid, o, o_sel and all i_ready go to 0 immediately and asynchronously. After release with i_valid=0, o_valid stays 0 and ptr=0.
- Single channel: N=4, only i_valid[2]=1, i[2]=0xA5, o_ready=1 -> i_ready=4'b0100. Next cycle o=0xA5, o_sel=2, o_valid=1, ptr=3.
- Round-robin fairness: N=4, RR=1, all i_valid=1 with i[k]=k+0x10, o_ready=1 for 8 cycles -> o_sel sequence 0,1,2,3,0,1,2,3. One word per cycle, no bubbles.
- Backpressure: all valid, o_ready=0 for 3 cycles after the first grant -> o and o_sel frozen, i_ready=0 throughout. On o_ready=1, transfers resume with the next channel in rotation and no word is lost or duplicated.
- Non-power-of-two wrap: N=3, RR=1, ptr=2, i_valid=3'b011 -> grant 0 (not an out-of-range index 3), then ptr=1.
- Fixed priority: RR=0, i_valid=4'b1010 held for 3 cycles with o_ready=1 -> o_sel=1 on every cycle. Channel 3 is starved, which is the intended behaviour in this mode.
